// File: rtl/piso_serial_tx_pkg.sv
// Shared MSI package: frame state encoding and counter-width helper for the serial link.
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } msi_state_e;

    // Smallest counter width able to hold WIDTH-1 (minimum one bit).
    function automatic int unsigned msi_cnt_w(input int unsigned width);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(width)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/piso_serial_tx_if.sv
// Load handshake and serial frame signals of the PISO transmitter.
interface piso_serial_tx_if #(
    parameter int unsigned WIDTH = 8
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             ser_valid;
    logic             frame_start;
    logic             frame_end;
    logic             busy;

    modport master (
        output load_valid, data_in,
        input  load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );

    modport slave (
        input  load_valid, data_in,
        output load_ready, ser_out, ser_valid, frame_start, frame_end, busy
    );
endinterface

// File: rtl/msi_down_counter.sv
// Loadable down counter with synchronous reset and a zero flag; holds the frame bit count.
module msi_down_counter #(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             zero_c
);
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count  = count_q;
    assign zero_c = (count_q == '0);
endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out transmitter, MSB first, with frame strobes.
// Define PISO_PARITY_EN to append an even-parity bit cycle to every frame.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input logic              clk,
    input logic              sync_reset,
    piso_serial_tx_if.slave  bus
);
    localparam int unsigned      CNT_W    = msi_cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    msi_state_e       state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             frame_start_q, frame_start_d;
    logic             frame_end_q, frame_end_d;
    logic             busy_q, busy_d;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    logic [CNT_W-1:0] cnt;
    logic             cnt_zero_c;
    logic             cnt_dec_c;
    logic             last_bit_c;
    logic             load_ready_c;
    logic             load_acc_c;

    // Final bit cycle of a frame is where the next word may be taken.
`ifdef PISO_PARITY_EN
    assign last_bit_c = (state_q == ST_PARITY);
`else
    assign last_bit_c = (state_q == ST_SHIFT) && cnt_zero_c;
`endif

    assign load_ready_c = (state_q == ST_IDLE) || last_bit_c;
    assign load_acc_c   = bus.load_valid && load_ready_c && !sync_reset;
    assign cnt_dec_c    = (state_q == ST_SHIFT) && !cnt_zero_c;

    msi_down_counter #(
        .CNT_W(CNT_W)
    ) u_bit_cnt (
        .clk       (clk),
        .sync_reset(sync_reset),
        .load      (load_acc_c),
        .load_val  (CNT_LAST),
        .dec       (cnt_dec_c),
        .count     (cnt),
        .zero_c    (cnt_zero_c)
    );

    always_comb begin
        state_d       = state_q;
        sr_d          = sr_q;
        ser_out_d     = 1'b0;
        ser_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        busy_d        = 1'b0;
`ifdef PISO_PARITY_EN
        par_d         = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (load_acc_c) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (!cnt_zero_c) begin
                    state_d = ST_SHIFT;
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = load_acc_c ? ST_SHIFT : ST_IDLE;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                state_d = load_acc_c ? ST_SHIFT : ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are computed for the cycle after this edge.
        if (load_acc_c) begin
            sr_d = WIDTH'(bus.data_in);
`ifdef PISO_PARITY_EN
            par_d = ^bus.data_in;
`endif
        end else if (state_q == ST_SHIFT) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end

        ser_valid_d   = (state_d != ST_IDLE);
        busy_d        = (state_d != ST_IDLE);
        frame_start_d = load_acc_c;

        if (state_d == ST_SHIFT) begin
            ser_out_d = sr_d[WIDTH-1];
        end
`ifdef PISO_PARITY_EN
        else if (state_d == ST_PARITY) begin
            ser_out_d = par_d;
        end
        frame_end_d = (state_q == ST_SHIFT) && cnt_zero_c;
`else
        frame_end_d = (state_q == ST_SHIFT) && (cnt == CNT_W'(1));
`endif
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state_q       <= ST_IDLE;
            sr_q          <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            busy_q        <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            busy_q        <= busy_d;
`ifdef PISO_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

    assign bus.load_ready  = load_ready_c;
    assign bus.ser_out     = ser_out_q;
    assign bus.ser_valid   = ser_valid_q;
    assign bus.frame_start = frame_start_q;
    assign bus.frame_end   = frame_end_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_piso_serial_tx.sv
// Directed, table-driven bench for piso_serial_tx (WIDTH=8); honours PISO_PARITY_EN.
module tb_piso_serial_tx;
    import piso_serial_tx_pkg::*;

`ifdef PISO_PARITY_EN
    localparam int unsigned FRAME_LEN = 9;
`else
    localparam int unsigned FRAME_LEN = 8;
`endif

    logic clk;
    logic rst;

    piso_serial_tx_if #(.WIDTH(8)) bus ();

    piso_serial_tx #(.WIDTH(8)) dut (
        .clk       (clk),
        .sync_reset(rst),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] din;
        logic       lr;
        logic       so;
        logic       sv;
        logic       fs;
        logic       fe;
        logic       bz;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    function automatic void v(input logic r, input logic lv, input logic [7:0] din,
                              input logic lr, input logic so, input logic sv,
                              input logic fs, input logic fe, input logic bz);
        vec_t e;
        e.rst = r;  e.lv = lv; e.din = din;
        e.lr  = lr; e.so = so; e.sv  = sv;
        e.fs  = fs; e.fe = fe; e.bz  = bz;
        vecs.push_back(e);
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         n_sv;
        logic [7:0] word;
        logic       got_end;

        n_checks = 0;
        n_fail   = 0;

        // rst lv din    lr so sv fs fe bz
`ifndef PISO_PARITY_EN
        // basic frame A5
        v(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 1, 1, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        // back-to-back A5 then 3C, load_valid held
        v(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
        v(0, 1, 8'h3C, 0, 1, 1, 1, 0, 1);
        v(0, 1, 8'h3C, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 0, 1, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 0, 1, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'h3C, 1, 1, 1, 0, 1, 1);
        v(0, 0, 8'h00, 0, 0, 1, 1, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 1, 0, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        // 00 frame with FF offered from cycle 3; accepted only in cycle 8
        v(0, 1, 8'h00, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 0, 1, 1, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'hFF, 1, 0, 1, 0, 1, 1);
        v(0, 0, 8'hFF, 0, 1, 1, 1, 0, 1);
        for (int k = 0; k < 6; k++) v(0, 0, 8'hFF, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'hFF, 1, 1, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        // reset in cycle 4 of A5, then 81
        v(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(1, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 1, 8'h81, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
        for (int k = 0; k < 6; k++) v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 1, 1, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
`else
        // A5 with parity bit 0
        v(0, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 1, 1, 1, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 1, 0, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        // 07 with parity bit 1
        v(0, 1, 8'h07, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 0, 0, 1, 1, 0, 1);
        for (int k = 0; k < 4; k++) v(0, 0, 8'h00, 0, 0, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 0, 1, 1, 0, 0, 1);
        v(0, 0, 8'h00, 1, 1, 1, 0, 1, 1);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
`endif
        // reset and load on the same edge: load dropped
        v(1, 1, 8'hA5, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);
        v(0, 0, 8'h00, 1, 0, 0, 0, 0, 0);

        rst            = 1'b1;
        bus.load_valid = 1'b0;
        bus.data_in    = 8'h00;
        repeat (2) @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst            = vecs[i].rst;
            bus.load_valid = vecs[i].lv;
            bus.data_in    = vecs[i].din;
            #1;
            chk("load_ready",  i, 32'(bus.load_ready),  32'(vecs[i].lr));
            chk("ser_out",     i, 32'(bus.ser_out),     32'(vecs[i].so));
            chk("ser_valid",   i, 32'(bus.ser_valid),   32'(vecs[i].sv));
            chk("frame_start", i, 32'(bus.frame_start), 32'(vecs[i].fs));
            chk("frame_end",   i, 32'(bus.frame_end),   32'(vecs[i].fe));
            chk("busy",        i, 32'(bus.busy),        32'(vecs[i].bz));
        end

        // Free-running frame of 5A collected until frame_end, with a cycle budget.
        @(negedge clk);
        rst            = 1'b0;
        bus.load_valid = 1'b1;
        bus.data_in    = 8'h5A;
        @(negedge clk);
        bus.load_valid = 1'b0;
        bus.data_in    = 8'hC3;
        #1;
        n_sv    = 0;
        word    = 8'h00;
        got_end = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (bus.ser_valid) begin
                n_sv++;
                if (n_sv <= 8) word = {word[6:0], bus.ser_out};
            end
            if (bus.frame_end) begin
                got_end = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
        end
        chk("hs_frame_end_seen", 0, 32'(got_end), 32'd1);
        chk("hs_frame_len",      0, 32'(n_sv),    32'(FRAME_LEN));
        chk("hs_word",           0, 32'(word),    32'h5A);
        @(negedge clk);
        #1;
        chk("hs_idle_busy",      0, 32'(bus.busy),       32'd0);
        chk("hs_idle_ready",     0, 32'(bus.load_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
